// File: rtl/serirq_module.sv
// SERIRQ peripheral agent: reports a level interrupt in IRQ data frame irq_num,
// follows host start/stop frames and issues quiet-mode start requests.
module serirq_module (
   input  logic       clk_i,
   input  logic       rst_i,
   inout  wire        serirq_io,
   input  logic [3:0] irq_num,
   input  logic       interrupt,
   output logic       continuous_o
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   typedef enum logic [1:0] {PH_SAMPLE, PH_RECOVERY, PH_TURN, PH_PRE} phase_t;

   state_t     state_q;
   phase_t     phase_q;
   logic [3:0] run_q;
   logic [4:0] frame_q;
   logic [3:0] irq_lat_q;
   logic       int_lat_q;
   logic       reported_q;
   logic       drv_en_q;
   logic       drv_val_q;

   phase_t     phase_d;
   logic [4:0] frame_d;
   logic [3:0] run_inc;
   logic       line_low;
   logic       own_frame;
   logic       own_frame_d;
   logic       quiet_req;

   assign serirq_io = drv_en_q ? drv_val_q : 1'bz;
   assign line_low  = !serirq_io;
   assign run_inc   = (run_q == 4'hF) ? run_q : run_q + 4'd1;
   assign quiet_req = !continuous_o && (irq_num != 4'd0) && (interrupt != reported_q);

   // phase_q/frame_q describe the clock after the current edge; the turn-around
   // clock R+1 that follows the start frame is the PH_PRE slot.
   always_comb begin
      phase_d = phase_q;
      frame_d = frame_q;
      unique case (phase_q)
         PH_PRE:      phase_d = PH_SAMPLE;
         PH_SAMPLE:   phase_d = PH_RECOVERY;
         PH_RECOVERY: phase_d = PH_TURN;
         PH_TURN: begin
            phase_d = PH_SAMPLE;
            frame_d = frame_q + 5'd1;
         end
      endcase
   end

   assign own_frame   = (irq_lat_q != 4'd0) && (frame_q == {1'b0, irq_lat_q});
   assign own_frame_d = (irq_lat_q != 4'd0) && (frame_d == {1'b0, irq_lat_q});

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         phase_q      <= PH_PRE;
         run_q        <= 4'd0;
         frame_q      <= 5'd0;
         irq_lat_q    <= 4'd0;
         int_lat_q    <= 1'b0;
         reported_q   <= 1'b0;
         drv_en_q     <= 1'b0;
         drv_val_q    <= 1'b0;
         continuous_o <= 1'b1;
      end else begin
         drv_en_q  <= 1'b0;
         drv_val_q <= 1'b0;
         run_q     <= line_low ? run_inc : 4'd0;
         unique case (state_q)
            IDLE: begin
               if (line_low) begin
                  state_q <= START;
                  run_q   <= 4'd1;
               end else if (quiet_req) begin
                  drv_en_q <= 1'b1;
               end
            end
            START: begin
               if (!line_low) begin
                  if (run_q >= 4'd4) begin
                     state_q   <= DATA;
                     irq_lat_q <= irq_num;
                     int_lat_q <= interrupt;
                     frame_q   <= 5'd0;
                     phase_q   <= PH_PRE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            DATA: begin
               if (line_low && run_q != 4'd0) begin
                  state_q <= STOP;
               end else if (phase_q == PH_TURN && frame_q == 5'd31) begin
                  state_q <= IDLE;
               end else begin
                  phase_q <= phase_d;
                  frame_q <= frame_d;
                  if (phase_q == PH_TURN && own_frame)
                     reported_q <= int_lat_q;
                  if (phase_d == PH_SAMPLE && own_frame_d && int_lat_q) begin
                     drv_en_q <= 1'b1;
                  end else if (phase_d == PH_RECOVERY && drv_en_q && !drv_val_q) begin
                     // actively restore the high level after our own low sample
                     drv_en_q  <= 1'b1;
                     drv_val_q <= 1'b1;
                  end
               end
            end
            STOP: begin
               if (!line_low) begin
                  if (run_q >= 4'd3)
                     continuous_o <= 1'b1;
                  else if (run_q == 4'd2)
                     continuous_o <= 1'b0;
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serirq_module.sv
// Directed bench for serirq_module: host waveforms and expected line levels are
// queued together, then replayed one clock at a time and compared mid-cycle.
module tb_serirq_module;

   logic       clk_i;
   logic       rst_i;
   logic [3:0] irq_num;
   logic       interrupt;
   logic       continuous_o;
   logic       host_low;
   wire        serirq_io;

   int checks;
   int errors;

   logic  hq[$];
   logic  eq[$];
   string tq[$];

   pullup (serirq_io);
   assign serirq_io = host_low ? 1'b0 : 1'bz;

   serirq_module dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .serirq_io(serirq_io),
      .irq_num(irq_num),
      .interrupt(interrupt),
      .continuous_o(continuous_o)
   );

   always #15 clk_i = ~clk_i;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic push(input logic h, input logic e, input string tag);
      hq.push_back(h);
      eq.push_back(e);
      tq.push_back(tag);
   endtask

   task automatic push_idle(input int n, input string tag);
      for (int i = 0; i < n; i++) push(1'b0, 1'b1, $sformatf("%s idle%0d", tag, i));
   endtask

   task automatic push_low(input int n, input string tag);
      for (int i = 0; i < n; i++) push(1'b1, 1'b0, $sformatf("%s low%0d", tag, i));
   endtask

   // dut_first: the first low clock comes from the block's own quiet-mode request
   task automatic push_start(input int len, input bit dut_first, input string tag);
      for (int i = 0; i < len; i++)
         push((dut_first && i == 0) ? 1'b0 : 1'b1, 1'b0, $sformatf("%s start%0d", tag, i));
      push(1'b0, 1'b1, $sformatf("%s R", tag));
      push(1'b0, 1'b1, $sformatf("%s R+1", tag));
   endtask

   task automatic push_frames(input int n, input int drive_frame, input string tag);
      for (int f = 0; f < n; f++) begin
         push(1'b0, (f == drive_frame) ? 1'b0 : 1'b1, $sformatf("%s f%0d smp", tag, f));
         push(1'b0, 1'b1, $sformatf("%s f%0d rec", tag, f));
         push(1'b0, 1'b1, $sformatf("%s f%0d ta", tag, f));
      end
   endtask

   task automatic push_stop(input int len, input string tag);
      push_low(len, {tag, " stop"});
      push(1'b0, 1'b1, $sformatf("%s stop end", tag));
   endtask

   // entered and left just after a rising edge
   task automatic play();
      while (hq.size() != 0) begin
         host_low = hq.pop_front();
         @(negedge clk_i);
         check(tq.pop_front(), serirq_io, eq.pop_front());
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      clk_i     = 1'b0;
      rst_i     = 1'b1;
      irq_num   = 4'd0;
      interrupt = 1'b0;
      host_low  = 1'b0;

      repeat (2) @(posedge clk_i);
      #1;
      check("reset line", serirq_io, 1'b1);
      check("reset mode", continuous_o, 1'b1);
      rst_i = 1'b0;

      irq_num = 4'd1; interrupt = 1'b1;
      push_idle(2, "c1"); push_start(4, 0, "c1"); push_frames(21, 1, "c1");
      push_stop(3, "c1"); push_idle(2, "c1post");
      play();
      check("c1 mode after stop3", continuous_o, 1'b1);

      irq_num = 4'd1; interrupt = 1'b0;
      push_start(4, 0, "deas"); push_frames(21, -1, "deas"); push_stop(3, "deas"); push_idle(2, "deas");
      play();
      irq_num = 4'd0; interrupt = 1'b1;
      push_start(4, 0, "dis"); push_frames(21, -1, "dis"); push_stop(3, "dis"); push_idle(2, "dis");
      play();
      check("dis mode", continuous_o, 1'b1);

      irq_num = 4'd0; interrupt = 1'b0;
      push_start(4, 0, "qent"); push_frames(21, -1, "qent"); push_stop(2, "qent"); push_idle(3, "qent");
      play();
      check("quiet entry mode", continuous_o, 1'b0);

      irq_num = 4'd10; interrupt = 1'b1;
      push_idle(1, "qreq"); push_start(4, 1, "qreq"); push_frames(21, 10, "qreq");
      push_stop(2, "qreq"); push_idle(8, "qreq no repeat");
      play();
      check("qreq mode", continuous_o, 1'b0);

      push_low(2, "glitch2"); push_idle(40, "glitch2");
      push_low(3, "glitch3"); push_idle(40, "glitch3");
      push_start(4, 0, "postglitch"); push_frames(21, 10, "postglitch");
      push_stop(2, "postglitch"); push_idle(4, "postglitch");
      play();
      check("postglitch mode", continuous_o, 1'b0);

      interrupt = 1'b0;
      push_idle(1, "qfall"); push_start(4, 1, "qfall"); push_frames(21, -1, "qfall");
      push_stop(2, "qfall"); push_idle(8, "qfall no repeat");
      play();

      interrupt = 1'b1;
      push_idle(1, "tmo"); push_start(4, 1, "tmo"); push_frames(32, 10, "tmo"); push_idle(6, "tmo");
      play();
      check("timeout mode kept", continuous_o, 1'b0);
      push_start(4, 0, "aftertmo"); push_frames(21, 10, "aftertmo");
      push_stop(2, "aftertmo"); push_idle(2, "aftertmo");
      play();
      check("aftertmo mode", continuous_o, 1'b0);

      push_start(4, 0, "rst"); push_frames(10, -1, "rst");
      play();
      check("rst pre drive", serirq_io, 1'b0);
      #2;
      rst_i = 1'b1;
      #1;
      check("rst line released", serirq_io, 1'b1);
      check("rst mode", continuous_o, 1'b1);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      push_idle(2, "post rst"); push_start(4, 0, "c2"); push_frames(21, 10, "c2");
      push_stop(3, "c2"); push_idle(2, "c2");
      play();
      check("c2 mode", continuous_o, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
